// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer
//   Sequences 16-bit unsigned shift-add multiply and restoring divide over
//   an external shared 16-bit adder/subtractor
//   (Sum = A + (B ^ Sub) + (Cin ^ Sub)).
//   Each operation takes 16 iterations, then spends one DONE cycle with a
//   Done pulse. A divide by zero skips straight to DONE.
//
// Ports
//   Clk, Rst         clock, synchronous active-high reset
//   Start, Op        request strobe (sampled in IDLE), 0 = mul, 1 = div
//   Op1, Op2         multiplicand/dividend, multiplier/divisor
//   Busy, Done       not-idle flag, one-cycle completion pulse
//   ResultHi/Lo      product[31:16]/[15:0], or remainder/quotient
//   DivByZero        divide with Op2 = 0, valid with Done
//   AddA/AddB/AddCin/AddSub   operands driven to the shared adder
//   AddSum/AddCout            adder results
//
// Configuration
//   MULDIV_DIV_EN    defined: divide supported.
//                    undefined: Op ignored, every request is a multiply,
//                    DivByZero tied to 0.
module mul_div_sequencer (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Op,
  input  logic [15:0] Op1,
  input  logic [15:0] Op2,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] ResultHi,
  output logic [15:0] ResultLo,
  output logic        DivByZero,
  output logic [15:0] AddA,
  output logic [15:0] AddB,
  output logic        AddCin,
  output logic        AddSub,
  input  logic [15:0] AddSum,
  input  logic        AddCout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
    DIV  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [15:0] hi, lo;        // P = {hi, lo} for multiply, R = hi / Q = lo for divide
  logic [15:0] operand2;      // latched multiplier or divisor
  logic [15:0] step_hi, step_lo;
  logic [15:0] result_hi, result_lo;

`ifdef MULDIV_DIV_EN
  logic [15:0] div_t;
  logic        div_ok;
  logic        div_by_zero;
  assign DivByZero = div_by_zero;
`else
  logic unused_op;
  assign unused_op = Op;
  assign DivByZero = 1'b0;
`endif

  assign Busy     = (state != IDLE);
  assign Done     = (state == DONE);
  assign ResultHi = result_hi;
  assign ResultLo = result_lo;

  // Next state, adder operands and the value of one iteration step
  always_comb begin
    state_next = state;
    step_hi    = hi;
    step_lo    = lo;
    AddA       = '0;
    AddB       = '0;
    AddCin     = 1'b0;
    AddSub     = 1'b0;
`ifdef MULDIV_DIV_EN
    div_t      = '0;
    div_ok     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (Start) begin
`ifdef MULDIV_DIV_EN
          if (!Op)             state_next = MUL;
          else if (Op2 != '0)  state_next = DIV;
          else                 state_next = DONE;
`else
          state_next = MUL;
`endif
        end
      end
      MUL: begin
        if (lo[0]) begin
          AddA = hi;
          AddB = operand2;
          {step_hi, step_lo} = {AddCout, AddSum, lo[15:1]};
        end else begin
          {step_hi, step_lo} = {1'b0, hi, lo[15:1]};
        end
        if (cnt == 4'd15) state_next = DONE;
      end
`ifdef MULDIV_DIV_EN
      DIV: begin
        div_t   = {hi[14:0], lo[15]};
        AddA    = div_t;
        AddB    = operand2;
        AddSub  = 1'b1;
        // hi[15] set means the shifted remainder overflowed 16 bits and is
        // certainly >= divisor even though the 16-bit subtract borrows.
        div_ok  = AddCout | hi[15];
        step_hi = div_ok ? AddSum : div_t;
        step_lo = {lo[14:0], div_ok};
        if (cnt == 4'd15) state_next = DONE;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      operand2  <= '0;
      result_hi <= '0;
      result_lo <= '0;
`ifdef MULDIV_DIV_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (Start) begin
            cnt      <= '0;
            hi       <= '0;
            lo       <= Op1;
            operand2 <= Op2;
`ifdef MULDIV_DIV_EN
            div_by_zero <= 1'b0;
            if (Op && (Op2 == '0)) begin
              result_hi   <= Op1;
              result_lo   <= '1;
              div_by_zero <= 1'b1;
            end
`endif
          end
        end
        DONE: ;
        default: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt + 4'd1;
          // Results are published from the last step so they are valid
          // during the DONE cycle.
          if (cnt == 4'd15) begin
            result_hi <= step_hi;
            result_lo <= step_lo;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb_mul_div_sequencer
//   Scoreboard bench for mul_div_sequencer. Stimulus pushes expected results
//   (with the cycle in which Done must appear); a monitor pops and compares on
//   every Done pulse. Expected values for Op = 1 follow MULDIV_DIV_EN.
module tb_mul_div_sequencer;

  logic        Clk = 1'b0;
  logic        Rst, Start, Op;
  logic [15:0] Op1, Op2;
  logic        Busy, Done, DivByZero;
  logic [15:0] ResultHi, ResultLo;
  logic [15:0] AddA, AddB, AddSum;
  logic        AddCin, AddSub, AddCout;
  logic [16:0] add_full;

  mul_div_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .Op1(Op1), .Op2(Op2),
    .Busy(Busy), .Done(Done), .ResultHi(ResultHi), .ResultLo(ResultLo),
    .DivByZero(DivByZero), .AddA(AddA), .AddB(AddB), .AddCin(AddCin),
    .AddSub(AddSub), .AddSum(AddSum), .AddCout(AddCout)
  );

  // Shared adder/subtractor
  assign add_full = {1'b0, AddA} + {1'b0, (AddB ^ {16{AddSub}})} + 17'(AddCin ^ AddSub);
  assign {AddCout, AddSum} = add_full;

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
    int unsigned done_cyc;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor
  always @(negedge Clk) begin
    if (Done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hi"},  {16'h0, ResultHi}, {16'h0, e.hi});
        chk({e.name, "_lo"},  {16'h0, ResultLo}, {16'h0, e.lo});
        chk({e.name, "_dbz"}, {31'h0, DivByZero}, {31'h0, e.dbz});
        chk({e.name, "_cyc"}, cyc, e.done_cyc);
        chk({e.name, "_add_idle"}, {AddA, AddB} | {30'h0, AddCin, AddSub}, 32'h0);
      end
    end
  end

  task automatic issue(input string name, input logic op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eh, input logic [15:0] el, input logic ed,
                       input int unsigned lat, input bit expect_done);
    exp_t e;
    @(negedge Clk);
    Start = 1'b1; Op = op; Op1 = a; Op2 = b;
    if (expect_done) begin
      e.name = name; e.hi = eh; e.lo = el; e.dbz = ed; e.done_cyc = cyc + lat;
      sb.push_back(e);
    end
    @(negedge Clk);
    Start = 1'b0; Op1 = ~a; Op2 = ~b; Op = ~op;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!Busy) begin ok = 1'b1; break; end
      @(negedge Clk);
    end
    if (!ok) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_busy"}, {31'h0, Busy}, 32'h0);
    chk({name, "_done"}, {31'h0, Done}, 32'h0);
    chk({name, "_res"},  {ResultHi, ResultLo}, 32'h0);
    chk({name, "_dbz"},  {31'h0, DivByZero}, 32'h0);
    chk({name, "_add"},  {AddA, AddB} | {30'h0, AddCin, AddSub}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1; Start = 1'b0; Op = 1'b0; Op1 = '0; Op2 = '0;
    repeat (3) @(negedge Clk);
    Start = 1'b1;  // ignored while in reset
    @(negedge Clk);
    chk_reset_state("reset");
    Rst = 1'b0; Start = 1'b0;

    issue("mul_1234x10", 1'b0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 17, 1'b1);
    chk("busy_running", {31'h0, Busy}, 32'h1);
    wait_idle("mul_1234x10");
    issue("mul_ffffxffff", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17, 1'b1);
    wait_idle("mul_ffffxffff");
    issue("mul_8000x2", 1'b0, 16'h8000, 16'h0002, 16'h0001, 16'h0000, 1'b0, 17, 1'b1);
    wait_idle("mul_8000x2");
    issue("mul_0x1234", 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17, 1'b1);
    wait_idle("mul_0x1234");

`ifdef MULDIV_DIV_EN
    issue("div_100_7", 1'b1, 16'd100, 16'd7, 16'd2, 16'd14, 1'b0, 17, 1'b1);
    wait_idle("div_100_7");
    issue("div_ffff_8001", 1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 17, 1'b1);
    wait_idle("div_ffff_8001");
    issue("div_by_zero", 1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1, 1'b1);
    wait_idle("div_by_zero");
    issue("div_after_dbz", 1'b1, 16'd9, 16'd3, 16'd0, 16'd3, 1'b0, 17, 1'b1);
    wait_idle("div_after_dbz");
`else
    issue("op1_100_7", 1'b1, 16'd100, 16'd7, 16'h0000, 16'h02BC, 1'b0, 17, 1'b1);
    wait_idle("op1_100_7");
    issue("op1_ffff_8001", 1'b1, 16'hFFFF, 16'h8001, 16'h8000, 16'h7FFF, 1'b0, 17, 1'b1);
    wait_idle("op1_ffff_8001");
    issue("op1_1234_0", 1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 17, 1'b1);
    wait_idle("op1_1234_0");
`endif

    // Second Start during a multiply must be ignored
    issue("mul_ignore_start", 1'b0, 16'h00FF, 16'h0101, 16'h0000, 16'hFFFF, 1'b0, 17, 1'b1);
    repeat (4) @(negedge Clk);
    Start = 1'b1; Op = 1'b0; Op1 = 16'hAAAA; Op2 = 16'h5555;
    @(negedge Clk);
    chk("busy_ignored_start", {31'h0, Busy}, 32'h1);
    Start = 1'b0;
    wait_idle("mul_ignore_start");

    // Reset in the middle of an operation aborts it without Done
    issue("abort", 1'b1, 16'd100, 16'd7, 16'h0, 16'h0, 1'b0, 17, 1'b0);
    repeat (8) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk_reset_state("abort_reset");
    Rst = 1'b0;
    repeat (20) @(negedge Clk);
    issue("mul_3x5", 1'b0, 16'd3, 16'd5, 16'd0, 16'd15, 1'b0, 17, 1'b1);
    wait_idle("mul_3x5");

    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
